seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 117 +++++++++++
 tb/tb_seq_divider.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle.
// Define SEQ_DIVIDER_EARLY_OUT_EN to finish in one cycle when |a| < |b|.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CntW-1:0]  cnt_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic             unused_diff;

  always_comb begin
    a_neg  = is_signed & a[WIDTH-1];
    b_neg  = is_signed & b[WIDTH-1];
    abs_a  = a_neg ? -a : a;
    abs_b  = b_neg ? -b : b;
    // Shifted remainder can reach 2*|b|-1, so it needs one extra bit.
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, dsr_q};
    borrow = diff[WIDTH+1];
  end

  // Bit WIDTH of diff is always zero when there is no borrow.
  assign unused_diff = diff[WIDTH];
  assign busy        = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      valid     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (b == '0) begin
              quotient  <= '1;
              remainder <= a;
              div_zero  <= 1'b1;
              valid     <= 1'b1;
            end else if (EarlyOut && (abs_a < abs_b)) begin
              quotient  <= '0;
              remainder <= a;
              div_zero  <= 1'b0;
              valid     <= 1'b1;
            end else begin
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              dvd_q     <= abs_a;
              dsr_q     <= abs_b;
              rem_q     <= '0;
              cnt_q     <= CntW'(WIDTH);
              state_q   <= StCalc;
            end
          end
        end
        StCalc: begin
          dvd_q <= {dvd_q[WIDTH-2:0], ~borrow};
          rem_q <= borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) state_q <= StFix;
        end
        StFix: begin
          quotient  <= neg_quo_q ? -dvd_q : dvd_q;
          remainder <= neg_rem_q ? -rem_q : rem_q;
          div_zero  <= 1'b0;
          valid     <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, protocol sequences and
// random operands checked against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 32;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif
  // Edges after the start edge until valid is visible on the full path.
  localparam int FullLat = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int t0       = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .valid     (valid),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    bit           s;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] q;
    logic [W-1:0] r;
    bit           dz;
    bit           short_op; // |a| < |b|: eligible for the early-out path
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact arithmetic in 64 bits, truncated back to W bits.
  function automatic void ref_div(input bit s, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output bit dz, output int lat);
    longint sx, sy, mx, my;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'(x);
      sy = longint'(y);
    end
    mx = (sx < 0) ? -sx : sx;
    my = (sy < 0) ? -sy : sy;
    if (y == '0) begin
      q = '1; r = x; dz = 1'b1; lat = 0;
    end else begin
      q   = W'(sx / sy);
      r   = W'(sx % sy);
      dz  = 1'b0;
      lat = (EarlyOut && (mx < my)) ? 0 : FullLat;
    end
  endfunction

  // Called just after a falling edge; returns just after the falling edge following the start edge.
  task automatic launch(input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
    is_signed = s;
    a         = x;
    b         = y;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_valid(output int lat, output bit busy_ok);
    busy_ok = 1'b1;
    while (!valid && (cyc - t0) < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
    end
    lat = valid ? (cyc - t0) : -1;
  endtask

  task automatic check_done(input string name, input logic [W-1:0] eq, input logic [W-1:0] er,
                            input bit edz, input int elat, input int lat, input bit busy_ok,
                            input bit hold);
    chk({name, " quotient"}, quotient, eq);
    chk({name, " remainder"}, remainder, er);
    chk({name, " div_zero"}, W'(div_zero), W'(edz));
    chk({name, " latency"}, W'(lat), W'(elat));
    chk({name, " busy_at_valid"}, W'(busy), '0);
    if (elat > 0) chk({name, " busy_while_calc"}, W'(busy_ok), W'(1));
    if (hold) begin
      @(negedge clk);
      chk({name, " valid_pulse"}, W'(valid), '0);
      chk({name, " hold"}, remainder, er);
    end
  endtask

  task automatic run_op(input string name, input bit s, input logic [W-1:0] x,
                        input logic [W-1:0] y);
    logic [W-1:0] eq, er;
    bit edz, bok;
    int elat, lat;
    ref_div(s, x, y, eq, er, edz, elat);
    launch(s, x, y);
    wait_valid(lat, bok);
    check_done(name, eq, er, edz, elat, lat, bok, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, elat, mode;
    bit bok, seen;
    logic [W-1:0] rx, ry;

    vecs[0]  = '{"u100_7",   1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0};
    vecs[1]  = '{"s-7_2",    1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[2]  = '{"u-7_2",    1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        1'b0, 1'b0};
    vecs[3]  = '{"u5_0",     1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1'b0};
    vecs[4]  = '{"s5_0",     1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1'b0};
    vecs[5]  = '{"s_ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b0};
    vecs[6]  = '{"u_ovf",    1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b1};
    vecs[7]  = '{"u3_10",    1'b0, 32'd3,        32'd10,       32'd0,        32'd3,        1'b0, 1'b1};
    vecs[8]  = '{"s-3_10",   1'b1, 32'hFFFFFFFD, 32'd10,       32'd0,        32'hFFFFFFFD, 1'b0, 1'b1};
    vecs[9]  = '{"s7_-2",    1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0};
    vecs[10] = '{"u_max_1",  1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", W'(busy), '0);
    chk("reset valid", W'(valid), '0);
    chk("reset quotient", quotient, '0);
    chk("reset remainder", remainder, '0);
    chk("reset div_zero", W'(div_zero), '0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      elat = vecs[i].dz ? 0 : ((vecs[i].short_op && EarlyOut) ? 0 : FullLat);
      launch(vecs[i].s, vecs[i].x, vecs[i].y);
      wait_valid(lat, bok);
      check_done(vecs[i].name, vecs[i].q, vecs[i].r, vecs[i].dz, elat, lat, bok, 1'b1);
    end

    // A new start mid-calculation must be ignored; operands may change while busy.
    launch(1'b0, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    is_signed = 1'b1; a = 32'd9; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    wait_valid(lat, bok);
    check_done("mid_calc_start", 32'd14, 32'd2, 1'b0, FullLat, lat, bok, 1'b1);

    // Start accepted in the valid cycle.
    launch(1'b0, 32'd1000, 32'd3);
    wait_valid(lat, bok);
    check_done("b2b_first", 32'd333, 32'd1, 1'b0, FullLat, lat, bok, 1'b0);
    is_signed = 1'b1; a = 32'hFFFFFFEC; b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    chk("b2b busy_after_accept", W'(busy), W'(1));
    chk("b2b valid_dropped", W'(valid), '0);
    wait_valid(lat, bok);
    check_done("b2b_second", 32'hFFFFFFFD, 32'hFFFFFFFE, 1'b0, FullLat, lat, bok, 1'b1);

    // Asynchronous reset at iteration 10 discards the operation.
    launch(1'b0, 32'd12345, 32'd17);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset busy", W'(busy), '0);
    chk("midreset valid", W'(valid), '0);
    chk("midreset quotient", quotient, '0);
    chk("midreset remainder", remainder, '0);
    chk("midreset div_zero", W'(div_zero), '0);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    chk("midreset no_valid", W'(seen), '0);
    run_op("post_reset", 1'b0, 32'd12345, 32'd17);

    for (int i = 0; i < 40; i++) begin
      rx   = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0:       ry = '0;
        1:       ry = W'($urandom_range(1, 15));
        2:       ry = 32'hFFFFFFFF;
        3:       begin rx = 32'h80000000; ry = $urandom; end
        4:       ry = rx >> $urandom_range(0, 31);
        default: ry = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), rx, ry);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
